// File: rtl/core_bus_pkg.sv
// Shared definitions for the core/data-cache request-response bus:
// tag field layout, encodings and the responder state machine states.
package core_bus_pkg;

    localparam int TAG_W         = 13;
    localparam int TAG_ID_W      = 10;
    localparam int TAG_RW_BIT    = 12;
    localparam int TAG_SPACE_BIT = 11;
    localparam int TAG_KIND_BIT  = 10;

    localparam logic READ   = 1'b1;
    localparam logic WRITE  = 1'b0;
    localparam logic MEMORY = 1'b0;
    localparam logic MMIO   = 1'b1;
    localparam logic DATA   = 1'b0;
    localparam logic INSN   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } resp_state_e;

endpackage

// File: rtl/dcache_backing_ram.sv
// Single-port DEPTH x 64 word store: synchronous write, registered read.
// Contents are intentionally not reset.
module dcache_backing_ram #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] addr,
    input  logic [63:0]      wdata,
    output logic [63:0]      rdata
);

    logic [63:0] mem [DEPTH];

    // Write port and registered read of the same address
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dcache_core_responder.sv
// Cache-side responder of the core/data-cache bus: accepts read/write beats,
// services them from a local backing array after LATENCY cycles and holds the response.
module dcache_core_responder
    import core_bus_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 3,
    parameter int TAG_W   = core_bus_pkg::TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reqcyc,
    input  logic [63:0]      req,
    input  logic [TAG_W-1:0] reqtag,
    output logic             reqack,
    output logic             respcyc,
    output logic [63:0]      resp,
    output logic [TAG_W-1:0] resptag,
    input  logic             respack,
    output logic             busy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    resp_state_e      state, next_state;
    logic [CNT_W-1:0] cnt, next_cnt;
    logic [IDX_W-1:0] idx, next_idx;
    logic [TAG_W-1:0] tag, next_tag;
    logic [63:0]      wdata, next_wdata;
    logic             next_reqack;
    logic             next_respcyc;
    logic [63:0]      next_resp;
    logic [TAG_W-1:0] next_resptag;
    logic             ram_we;
    logic [IDX_W-1:0] ram_addr;
    logic [63:0]      ram_rdata;

    // In IDLE the RAM is addressed straight from the request so read data is
    // already registered by the time a LATENCY=1 response is loaded.
    assign ram_addr = (state == IDLE) ? req[3 +: IDX_W] : idx;

    dcache_backing_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata),
        .rdata (ram_rdata)
    );

    // Next-state, latch and response computation
    always_comb begin
        next_state   = state;
        next_cnt     = cnt;
        next_idx     = idx;
        next_tag     = tag;
        next_wdata   = wdata;
        next_reqack  = 1'b0;
        next_respcyc = respcyc;
        next_resp    = resp;
        next_resptag = resptag;
        ram_we       = 1'b0;
        case (state)
            IDLE: begin
                if (reqcyc) begin
                    next_idx    = req[3 +: IDX_W];
                    next_tag    = reqtag;
                    next_reqack = 1'b1;
                    next_cnt    = '0;
                    if (reqtag[TAG_RW_BIT] == READ) begin
                        next_state = WAIT;
                    end else begin
                        next_state = WDATA;
                    end
                end else begin
                    next_state = IDLE;
                end
            end
            WDATA: begin
                if (reqcyc) begin
                    next_wdata  = req;
                    next_reqack = 1'b1;
                    next_cnt    = '0;
                    next_state  = WAIT;
                end else begin
                    next_state = WDATA;
                end
            end
            WAIT: begin
                if (cnt == CNT_LAST) begin
                    next_state   = RESP;
                    next_respcyc = 1'b1;
                    next_resptag = tag;
                    if (tag[TAG_RW_BIT] == READ) begin
                        next_resp = ram_rdata;
                    end else begin
                        next_resp = 64'd0;
                        ram_we    = 1'b1;
                    end
                end else begin
                    next_cnt = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                // Any reqcyc here is left pending and picked up from IDLE
                if (respack) begin
                    next_respcyc = 1'b0;
                    next_state   = IDLE;
                end else begin
                    next_state = RESP;
                end
            end
            default: begin
                next_state   = IDLE;
                next_respcyc = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            tag     <= '0;
            wdata   <= 64'd0;
            reqack  <= 1'b0;
            respcyc <= 1'b0;
            resp    <= 64'd0;
            resptag <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= next_state;
            cnt     <= next_cnt;
            idx     <= next_idx;
            tag     <= next_tag;
            wdata   <= next_wdata;
            reqack  <= next_reqack;
            respcyc <= next_respcyc;
            resp    <= next_resp;
            resptag <= next_resptag;
            busy    <= (next_state != IDLE);
        end
    end

endmodule
